// File: rtl/layer_buf_pkg.sv
// Shared constants and enums for the layer3 buffer controller.
// Imported by the top and by the read-return slice.
package layer_buf_pkg;
  localparam int DEPTH = 208;
  localparam int AW    = 8;
  localparam int DW    = 128;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } buf_state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_B,
    SEL_ZERO
  } rsel_t;
endpackage

// File: rtl/lbuf_rd_return.sv
// Per-reader return path: remembers which port serves the
// accepted read and muxes SRAM data one cycle later.
module lbuf_rd_return
  import layer_buf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          fire,
  input  rsel_t         sel,
  input  logic [DW-1:0] sram_doa,
  input  logic [DW-1:0] sram_dob,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  rsel_t sel_d, sel_q;

  always_comb begin
    sel_d = fire ? sel : SEL_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) sel_q <= SEL_NONE;
    else     sel_q <= sel_d;
  end

  always_comb begin
    rvalid = (sel_q != SEL_NONE);
    rdata  = '0;
    unique case (sel_q)
      SEL_A:   rdata = sram_doa;
      SEL_B:   rdata = sram_dob;
      default: rdata = '0;
    endcase
  end
endmodule

// File: rtl/layer3_buf_ctrl.sv
// Layer3 buffer sequencer: fills rows sequentially and lets two
// readers consume rows below the write watermark.
module layer3_buf_ctrl
  import layer_buf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic          rd0_valid,
  output logic          rd0_ready,
  input  logic [AW-1:0] rd0_addr,
  output logic          rd0_rvalid,
  output logic [DW-1:0] rd0_rdata,
  input  logic          rd1_valid,
  output logic          rd1_ready,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_rvalid,
  output logic [DW-1:0] rd1_rdata,
  output logic          layer_done,
  output logic          addr_err,
  output logic          sram_oea,
  output logic          sram_oeb,
  output logic          sram_wean,
  output logic          sram_webn,
  output logic [AW-1:0] sram_a,
  output logic [AW-1:0] sram_b,
  output logic [DW-1:0] sram_dia,
  output logic [DW-1:0] sram_dib,
  input  logic [DW-1:0] sram_doa,
  input  logic [DW-1:0] sram_dob
);
  localparam logic [AW-1:0] A_DEPTH = AW'(DEPTH);
  localparam logic [AW-1:0] A_LAST  = AW'(DEPTH - 1);

  buf_state_t    state_d, state_q;
  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic          addr_err_d, addr_err_q;

  logic  wr_fire, rd0_fire, rd1_fire;
  logic  avail0, avail1, oor0, oor1, merge;
  rsel_t sel0, sel1;

  always_comb begin
    oor0   = (rd0_addr >= A_DEPTH);
    oor1   = (rd1_addr >= A_DEPTH);
    avail0 = (rd0_addr < wr_ptr_q) || (state_q == FULL);
    avail1 = (rd1_addr < wr_ptr_q) || (state_q == FULL);

    wr_ready  = (state_q == FILL);
    wr_fire   = wr_valid && wr_ready;
    rd0_ready = (state_q != IDLE) && avail0;
    rd1_ready = (state_q != IDLE) && avail1 && !wr_fire;
    rd0_fire  = rd0_valid && rd0_ready;
    rd1_fire  = rd1_valid && rd1_ready;
    merge     = rd0_fire && rd1_fire && (rd0_addr == rd1_addr);

    sel0 = oor0 ? SEL_ZERO : SEL_B;
    sel1 = oor1 ? SEL_ZERO : (merge ? SEL_B : SEL_A);

    sram_oea  = 1'b0;
    sram_wean = 1'b1;
    sram_a    = '0;
    sram_dia  = '0;
    sram_oeb  = 1'b0;
    sram_webn = 1'b1;
    sram_b    = '0;
    sram_dib  = '0;

    // Port A: producer has strict priority over host readback
    if (wr_fire) begin
      sram_wean = 1'b0;
      sram_a    = wr_ptr_q;
      sram_dia  = wr_data;
    end else if (rd1_fire && sel1 == SEL_A) begin
      sram_oea = 1'b1;
      sram_a   = rd1_addr;
    end

    if (rd0_fire && !oor0) begin
      sram_oeb = 1'b1;
      sram_b   = rd0_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    addr_err_d = addr_err_q
               | (rd0_fire && oor0)
               | (rd1_fire && oor1);
    if (start) begin
      state_d    = FILL;
      wr_ptr_d   = '0;
      addr_err_d = 1'b0;
    end else if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == A_LAST) state_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign layer_done = (state_q == FULL);
  assign addr_err   = addr_err_q;

  lbuf_rd_return u_ret0 (
    .clk      (clk),
    .rst      (rst),
    .fire     (rd0_fire),
    .sel      (sel0),
    .sram_doa (sram_doa),
    .sram_dob (sram_dob),
    .rvalid   (rd0_rvalid),
    .rdata    (rd0_rdata)
  );

  lbuf_rd_return u_ret1 (
    .clk      (clk),
    .rst      (rst),
    .fire     (rd1_fire),
    .sel      (sel1),
    .sram_doa (sram_doa),
    .sram_dob (sram_dob),
    .rvalid   (rd1_rvalid),
    .rdata    (rd1_rdata)
  );
endmodule

// File: tb/tb_layer3_buf_ctrl.sv
// Directed bench for layer3_buf_ctrl with a behavioural
// dual-port synchronous SRAM model.
module tb_layer3_buf_ctrl;
  import layer_buf_pkg::*;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd0_valid, rd0_ready, rd0_rvalid;
  logic [AW-1:0] rd0_addr;
  logic [DW-1:0] rd0_rdata;
  logic          rd1_valid, rd1_ready, rd1_rvalid;
  logic [AW-1:0] rd1_addr;
  logic [DW-1:0] rd1_rdata;
  logic          layer_done, addr_err;
  logic          sram_oea, sram_oeb, sram_wean, sram_webn;
  logic [AW-1:0] sram_a, sram_b;
  logic [DW-1:0] sram_dia, sram_dib;
  logic [DW-1:0] sram_doa, sram_dob;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  layer3_buf_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd0_valid  (rd0_valid),
    .rd0_ready  (rd0_ready),
    .rd0_addr   (rd0_addr),
    .rd0_rvalid (rd0_rvalid),
    .rd0_rdata  (rd0_rdata),
    .rd1_valid  (rd1_valid),
    .rd1_ready  (rd1_ready),
    .rd1_addr   (rd1_addr),
    .rd1_rvalid (rd1_rvalid),
    .rd1_rdata  (rd1_rdata),
    .layer_done (layer_done),
    .addr_err   (addr_err),
    .sram_oea   (sram_oea),
    .sram_oeb   (sram_oeb),
    .sram_wean  (sram_wean),
    .sram_webn  (sram_webn),
    .sram_a     (sram_a),
    .sram_b     (sram_b),
    .sram_dia   (sram_dia),
    .sram_dib   (sram_dib),
    .sram_doa   (sram_doa),
    .sram_dob   (sram_dob)
  );

  logic [DW-1:0] mem [0:255];

  always @(posedge clk) begin
    if (!sram_wean) mem[sram_a] <= sram_dia;
    if (sram_oea)   sram_doa <= mem[sram_a];
    if (sram_oeb)   sram_dob <= mem[sram_b];
  end

  function automatic logic [DW-1:0] dw(input int i);
    logic [31:0] u;
    u = 32'(i);
    return {32'hC0DE0000 + u, u * 32'h9E3779B9,
            ~u, 32'hA5A50000 ^ u};
  endfunction

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    sram_doa = '0;
    sram_dob = '0;
    rst = 1'b1; start = 1'b0;
    wr_valid = 1'b0; wr_data = '0;
    rd0_valid = 1'b0; rd0_addr = '0;
    rd1_valid = 1'b0; rd1_addr = '0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd0_ready", rd0_ready, 0);
    chk("rst_rd1_ready", rd1_ready, 0);
    chk("rst_rvalid", {rd0_rvalid, rd1_rvalid}, 0);
    chk("rst_rdata0", rd0_rdata, 0);
    chk("rst_rdata1", rd1_rdata, 0);
    chk("rst_done_err", {layer_done, addr_err}, 0);
    chk("rst_oe", {sram_oea, sram_oeb}, 0);
    chk("rst_we", {sram_wean, sram_webn}, 2'b11);
    chk("rst_addr", {sram_a, sram_b}, 0);
    chk("rst_din", sram_dia | sram_dib, 0);

    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_wr_ready", wr_ready, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // five back-to-back writes
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = dw(i);
      #1;
      chk($sformatf("w%0d_ready", i), wr_ready, 1);
      chk($sformatf("w%0d_wean", i), sram_wean, 0);
      chk($sformatf("w%0d_oea", i), sram_oea, 0);
      chk($sformatf("w%0d_a", i), sram_a, i);
      chk($sformatf("w%0d_dia", i), sram_dia, dw(i));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rd0_addr = 8'd4;
    #1;
    chk("wm_addr4_ready", rd0_ready, 1);
    rd0_addr = 8'd5;
    #1;
    chk("wm_addr5_stall", rd0_ready, 0);

    // read waits on the watermark, then returns the new word
    rd0_valid = 1'b1;
    wr_valid  = 1'b1;
    wr_data   = dw(5);
    #1;
    chk("wm_stall", rd0_ready, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("wm_release", rd0_ready, 1);
    chk("wm_oeb", sram_oeb, 1);
    chk("wm_b", sram_b, 5);
    @(negedge clk);
    rd0_valid = 1'b0;
    #1;
    chk("wm_rvalid", rd0_rvalid, 1);
    chk("wm_rdata", rd0_rdata, dw(5));
    @(negedge clk);
    #1;
    chk("wm_rvalid_pulse", rd0_rvalid, 0);

    // write beats host readback on port A
    wr_valid  = 1'b1;
    wr_data   = dw(6);
    rd1_valid = 1'b1;
    rd1_addr  = 8'd0;
    #1;
    chk("arb_rd1_stall", rd1_ready, 0);
    chk("arb_oea", sram_oea, 0);
    chk("arb_a", sram_a, 6);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("arb_rd1_ready", rd1_ready, 1);
    chk("arb_rd_oea", sram_oea, 1);
    chk("arb_rd_a", sram_a, 0);
    @(negedge clk);
    rd1_valid = 1'b0;
    #1;
    chk("arb_rvalid", rd1_rvalid, 1);
    chk("arb_rdata", rd1_rdata, dw(0));

    // fill to the end
    for (int i = 7; i < DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = dw(i);
      if (i == DEPTH - 1) begin
        #1;
        chk("last_wr_ready", wr_ready, 1);
        chk("last_not_done", layer_done, 0);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    chk("full_done", layer_done, 1);
    chk("full_wr_ready", wr_ready, 0);

    // same-address merge in FULL
    rd0_valid = 1'b1; rd0_addr = 8'd100;
    rd1_valid = 1'b1; rd1_addr = 8'd100;
    #1;
    chk("mrg_ready", {rd0_ready, rd1_ready}, 2'b11);
    chk("mrg_oe", {sram_oea, sram_oeb}, 2'b01);
    chk("mrg_b", sram_b, 100);
    @(negedge clk);
    rd0_valid = 1'b0; rd1_valid = 1'b0;
    #1;
    chk("mrg_rvalid", {rd0_rvalid, rd1_rvalid}, 2'b11);
    chk("mrg_rdata0", rd0_rdata, dw(100));
    chk("mrg_rdata1", rd1_rdata, dw(100));

    // distinct addresses, top row on port A
    rd0_valid = 1'b1; rd0_addr = 8'd10;
    rd1_valid = 1'b1; rd1_addr = 8'd207;
    #1;
    chk("dual_oe", {sram_oea, sram_oeb}, 2'b11);
    chk("dual_a", sram_a, 207);
    @(negedge clk);
    rd0_valid = 1'b0; rd1_valid = 1'b0;
    #1;
    chk("dual_rdata0", rd0_rdata, dw(10));
    chk("dual_rdata1", rd1_rdata, dw(207));

    // out-of-range read in FULL
    rd1_valid = 1'b1; rd1_addr = 8'd210;
    #1;
    chk("oor_ready", rd1_ready, 1);
    chk("oor_oea", sram_oea, 0);
    @(negedge clk);
    rd1_valid = 1'b0;
    #1;
    chk("oor_rvalid", rd1_rvalid, 1);
    chk("oor_rdata", rd1_rdata, 0);
    chk("oor_err", addr_err, 1);
    @(negedge clk);
    #1;
    chk("oor_err_sticky", addr_err, 1);

    // restart clears state
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd0_addr = 8'd0;
    #1;
    chk("rs_err", addr_err, 0);
    chk("rs_done", layer_done, 0);
    chk("rs_wr_ready", wr_ready, 1);
    chk("rs_wm", rd0_ready, 0);

    // reset during an accepted read drops rvalid
    wr_valid = 1'b1;
    wr_data  = dw(42);
    @(negedge clk);
    wr_valid  = 1'b0;
    rd0_valid = 1'b1;
    rd0_addr  = 8'd0;
    #1;
    chk("rr_ready", rd0_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd0_valid = 1'b0;
    #1;
    chk("rr_rvalid", rd0_rvalid, 0);
    chk("rr_rdata", rd0_rdata, 0);
    chk("rr_wr_ready", wr_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
